e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- Execute-stage multiply/divide unit with the architectural HI/LO registers.
- Consumes the operands, instruction decode and exception flush that the D->E pipeline register presents to the E stage.
- Runs MULT/MULTU/DIV/DIVU as multi-cycle operations behind a busy flag. The hazard unit uses that flag to stall the pipeline.
- Also executes MTHI/MTLO and supplies HI/LO for MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for MULT/MULTU (>=1)
- DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (>=1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- Req  in  1  exception/interrupt flush; the instruction currently in E must not take effect
- start  in  1  one-cycle issue strobe for the op in E (already gated by the stall logic)
- op  in  4  MDU operation, encoding from mdu_pkg
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- busy  out  1  multi-cycle operation in flight
- HI  out  32  architectural HI
- LO  out  32  architectural LO

Behaviour:
- Reset (reset==0 at an edge): HI=0, LO=0, busy=0, counter=0; pending result discarded. Reset mid-operation aborts it, and HI/LO stay 0.
- Accepted issue: start==1 && Req==0 && busy==0 at edge k.
- MULT/MULTU: 64-bit signed/unsigned product latched into pend_hi/pend_lo; counter<=MULT_CYCLES.
- DIV/DIVU: pend_lo = quotient, pend_hi = remainder, signed/unsigned, truncating toward zero; remainder takes the dividend's sign; counter<=DIV_CYCLES.
- DIV by B==0: no pending write. busy still runs DIV_CYCLES; HI/LO unchanged.
- Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (32-bit wrap).
- MTHI/MTLO: HI or LO <= A at edge k, single cycle, busy not raised.
- MFHI/MFLO: no state change; readers use the HI/LO outputs.
- busy is registered and equals counter!=0. It is high for exactly N cycles after edge k.
- The counter decrements each edge. At the edge where counter==1, HI/LO <= pending and counter <= 0. The result is visible from edge k+N.
- Req==1 with start==1: the op is discarded, including MTHI/MTLO. No state change.
- Req while busy: the in-flight op belongs to an older instruction and completes normally.
- start while busy: ignored, with no state change. This is a protocol violation; the bench flags it.
- Unused op codes with start: ignored.
- Operands are sampled only at the issue edge. Later changes to A/B have no effect.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: adds MADD, MADDU, MSUB, MSUBU.
  - Pending value = {HI,LO} +/- signed/unsigned product, computed mod 2^64 from HI/LO at issue.
  - Latency MULT_CYCLES.
  - A new MTHI/MTLO cannot coexist with one of these ops because busy blocks issue.
- Undefined: these codes are unused and ignored.

Decomposition:
- mdu_pkg holds:
  - op encodings: MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12
  - default latency constants
  - the 4-bit op width
- One sub-module, mdu_compute: purely combinational 64-bit product/quotient/remainder from (op, A, B, HI, LO). e_mdu keeps the counter, pending registers and HI/LO.

Test Plan:
- MULT A=0xFFFFFFFE (-2), B=3 at edge k -> busy high k+1..k+5; from edge k+5, HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x2, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
- DIV B=0 with HI=0x11, LO=0x22 -> busy for 10 cycles, then HI=0x11, LO=0x22. Signed 0x80000000/-1 -> LO=0x80000000, HI=0.
- start=1 with Req=1 for MULT and for MTHI A=0x55 -> busy stays 0, HI/LO unchanged. Req asserted on cycle 3 of an ongoing DIV -> DIV completes with correct results.
- MTLO A=0x1234 -> LO=0x1234 next cycle, busy=0. start during busy -> ignored, first result intact. reset=0 at cycle 2 of a MULT -> HI=LO=0, busy=0 next cycle.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 -> HI=1, LO=0 after 5 cycles. MSUB A=1, B=1 from 0 -> HI=LO=0xFFFFFFFF.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Defining MDU_MADD_EN adds the multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU).
package mdu_pkg;

    localparam int MDU_OP_W        = 4;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_NONE = 4'd0,
        MULT     = 4'd1,
        MULTU    = 4'd2,
        DIV      = 4'd3,
        DIVU     = 4'd4,
        MTHI     = 4'd5,
        MTLO     = 4'd6,
        MFHI     = 4'd7,
        MFLO     = 4'd8,
        MADD     = 4'd9,
        MADDU    = 4'd10,
        MSUB     = 4'd11,
        MSUBU    = 4'd12
    } mdu_op_e;

    // Ops that run for MULT_CYCLES; accumulate ops only exist when enabled.
    function automatic logic is_mul_class(input logic [MDU_OP_W-1:0] op);
        logic r;
        r = (op == MULT) || (op == MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
`endif
        return r;
    endfunction

    function automatic logic is_div_class(input logic [MDU_OP_W-1:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_compute.sv
// Combinational datapath: 64-bit product, quotient/remainder and optional accumulate.
// Accumulate ops are present only when MDU_MADD_EN is defined.
module mdu_compute
    import mdu_pkg::*;
(
    input  logic [MDU_OP_W-1:0] op,
    input  logic [31:0]         A,
    input  logic [31:0]         B,
    input  logic [31:0]         HI,
    input  logic [31:0]         LO,
    output logic [63:0]         result,
    output logic                wr_en
);

    logic        sgn;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_div;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Signed division goes through magnitudes, so 0x80000000 / -1 wraps to 0x80000000.
    always_comb begin
        sgn = (op == MULT) || (op == DIV);
`ifdef MDU_MADD_EN
        sgn = sgn || (op == MADD) || (op == MSUB);
`endif
        a_ext   = sgn ? {{32{A[31]}}, A} : {32'b0, A};
        b_ext   = sgn ? {{32{B[31]}}, B} : {32'b0, B};
        product = a_ext * b_ext;

        a_mag = (sgn && A[31]) ? -A : A;
        b_mag = (sgn && B[31]) ? -B : B;
        b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag = a_mag / b_div;
        r_mag = a_mag % b_div;
        quot  = (sgn && (A[31] ^ B[31])) ? -q_mag : q_mag;
        rem   = (sgn && A[31]) ? -r_mag : r_mag;

        result = '0;
        wr_en  = 1'b0;
        case (mdu_op_e'(op))
            MULT, MULTU: begin
                result = product;
                wr_en  = 1'b1;
            end
            DIV, DIVU: begin
                result = {rem, quot};
                wr_en  = (B != 32'd0);
            end
`ifdef MDU_MADD_EN
            MADD, MADDU: begin
                result = {HI, LO} + product;
                wr_en  = 1'b1;
            end
            MSUB, MSUBU: begin
                result = {HI, LO} - product;
                wr_en  = 1'b1;
            end
`endif
            default: begin
                result = '0;
                wr_en  = 1'b0;
            end
        endcase
    end

`ifndef MDU_MADD_EN
    logic unused_hilo;
    assign unused_hilo = ^{HI, LO};
`endif

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning HI/LO; busy stalls the pipeline while an op runs.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Req,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] op,
    input  logic [31:0]         A,
    input  logic [31:0]         B,
    output logic                busy,
    output logic [31:0]         HI,
    output logic [31:0]         LO
);

    localparam int CNT_W = 16;

    logic [CNT_W-1:0] counter;
    logic [63:0]      pend;
    logic             pend_valid;
    logic [63:0]      result;
    logic             wr_en;
    logic             issue;

    mdu_compute u_compute (
        .op     (op),
        .A      (A),
        .B      (B),
        .HI     (HI),
        .LO     (LO),
        .result (result),
        .wr_en  (wr_en)
    );

    assign issue = start && !Req && (counter == '0);
    assign busy  = (counter != '0);

    // Result is computed at issue and held in pend; HI/LO commit on the last busy edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            HI         <= '0;
            LO         <= '0;
            counter    <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else if (counter != '0) begin
            counter <= counter - CNT_W'(1);
            if (counter == CNT_W'(1) && pend_valid) begin
                HI <= pend[63:32];
                LO <= pend[31:0];
            end
        end else if (issue) begin
            if (is_mul_class(op)) begin
                pend       <= result;
                pend_valid <= 1'b1;
                counter    <= CNT_W'(MULT_CYCLES);
            end else if (is_div_class(op)) begin
                pend       <= result;
                pend_valid <= wr_en;
                counter    <= CNT_W'(DIV_CYCLES);
            end else if (op == MTHI) begin
                HI <= A;
            end else if (op == MTLO) begin
                LO <= A;
            end
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu with hand-computed HI/LO and busy lengths.
// Accumulate tests run only when MDU_MADD_EN is defined.
module tb_e_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        Req;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int fails  = 0;
    int violations = 0;

    e_mdu dut (
        .clk   (clk),
        .reset (reset),
        .Req   (Req),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitor: issuing while busy is a pipeline bug.
    always @(posedge clk) begin
        if (reset === 1'b1 && start === 1'b1 && busy === 1'b1) begin
            violations++;
            $display("[TB] protocol violation: start asserted while busy at %0t", $time);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic rq);
        @(negedge clk);
        op = o; A = a; B = b; Req = rq; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; Req = 1'b0; op = 4'd0; A = $urandom; B = $urandom;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; Req = 1'b0; op = 4'd0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (HI !== 32'h0) begin fails++; $display("[TB] FAIL reset_hi: got %h expected %h", HI, 32'h0); end
        checks++; if (LO !== 32'h0) begin fails++; $display("[TB] FAIL reset_lo: got %h expected %h", LO, 32'h0); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_mult();
        int n;
        issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        count_busy(n);
        checks++; if (n != 5) begin fails++; $display("[TB] FAIL mult_busy_len: got %0d expected 5", n); end
        checks++; if (HI !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", HI); end
        checks++; if (LO !== 32'hFFFFFFFA) begin fails++; $display("[TB] FAIL mult_lo: got %h expected fffffffa", LO); end
        issue(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0);
        count_busy(n);
        checks++; if (n != 5) begin fails++; $display("[TB] FAIL multu_busy_len: got %0d expected 5", n); end
        checks++; if (HI !== 32'h2) begin fails++; $display("[TB] FAIL multu_hi: got %h expected 00000002", HI); end
        checks++; if (LO !== 32'hFFFFFFFA) begin fails++; $display("[TB] FAIL multu_lo: got %h expected fffffffa", LO); end
    endtask

    task automatic test_div();
        int n;
        issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        count_busy(n);
        checks++; if (n != 10) begin fails++; $display("[TB] FAIL div_busy_len: got %0d expected 10", n); end
        checks++; if (LO !== 32'hFFFFFFFD) begin fails++; $display("[TB] FAIL div_lo: got %h expected fffffffd", LO); end
        checks++; if (HI !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL div_hi: got %h expected ffffffff", HI); end
        issue(4'd4, 32'd7, 32'd2, 1'b0);
        count_busy(n);
        checks++; if (n != 10) begin fails++; $display("[TB] FAIL divu_busy_len: got %0d expected 10", n); end
        checks++; if (LO !== 32'd3) begin fails++; $display("[TB] FAIL divu_lo: got %h expected 00000003", LO); end
        checks++; if (HI !== 32'd1) begin fails++; $display("[TB] FAIL divu_hi: got %h expected 00000001", HI); end
    endtask

    task automatic test_div_zero();
        int n;
        issue(4'd5, 32'h11, 32'h0, 1'b0);
        issue(4'd6, 32'h22, 32'h0, 1'b0);
        issue(4'd3, 32'd5, 32'd0, 1'b0);
        count_busy(n);
        checks++; if (n != 10) begin fails++; $display("[TB] FAIL divzero_busy_len: got %0d expected 10", n); end
        checks++; if (HI !== 32'h11) begin fails++; $display("[TB] FAIL divzero_hi: got %h expected 00000011", HI); end
        checks++; if (LO !== 32'h22) begin fails++; $display("[TB] FAIL divzero_lo: got %h expected 00000022", LO); end
        issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        count_busy(n);
        checks++; if (LO !== 32'h80000000) begin fails++; $display("[TB] FAIL divovf_lo: got %h expected 80000000", LO); end
        checks++; if (HI !== 32'h0) begin fails++; $display("[TB] FAIL divovf_hi: got %h expected 00000000", HI); end
    endtask

    task automatic test_req();
        issue(4'd1, 32'd2, 32'd3, 1'b1);
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL req_mult_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        checks++; if (HI !== 32'h0) begin fails++; $display("[TB] FAIL req_mult_hi: got %h expected 00000000", HI); end
        checks++; if (LO !== 32'h80000000) begin fails++; $display("[TB] FAIL req_mult_lo: got %h expected 80000000", LO); end
        issue(4'd5, 32'h55, 32'h0, 1'b1);
        checks++; if (HI !== 32'h0) begin fails++; $display("[TB] FAIL req_mthi_hi: got %h expected 00000000", HI); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL req_mthi_busy: got %b expected 0", busy); end
    endtask

    task automatic test_req_busy();
        int n;
        issue(4'd4, 32'd100, 32'd7, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk); Req = 1'b1;
        @(posedge clk); #1;
        Req = 1'b0;
        count_busy(n);
        checks++; if (n + 3 != 10) begin fails++; $display("[TB] FAIL reqbusy_len: got %0d expected 10", n + 3); end
        checks++; if (LO !== 32'd14) begin fails++; $display("[TB] FAIL reqbusy_lo: got %h expected 0000000e", LO); end
        checks++; if (HI !== 32'd2) begin fails++; $display("[TB] FAIL reqbusy_hi: got %h expected 00000002", HI); end
    endtask

    task automatic test_mt();
        issue(4'd6, 32'h1234, 32'h0, 1'b0);
        checks++; if (LO !== 32'h1234) begin fails++; $display("[TB] FAIL mtlo_lo: got %h expected 00001234", LO); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL mtlo_busy: got %b expected 0", busy); end
        checks++; if (HI !== 32'd2) begin fails++; $display("[TB] FAIL mtlo_hi: got %h expected 00000002", HI); end
    endtask

    task automatic test_start_busy();
        int n;
        violations = 0;
        issue(4'd2, 32'd6, 32'd7, 1'b0);
        @(negedge clk);
        op = 4'd4; A = 32'd1; B = 32'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 4'd0;
        count_busy(n);
        checks++; if (n + 1 != 5) begin fails++; $display("[TB] FAIL startbusy_len: got %0d expected 5", n + 1); end
        checks++; if (LO !== 32'd42) begin fails++; $display("[TB] FAIL startbusy_lo: got %h expected 0000002a", LO); end
        checks++; if (HI !== 32'd0) begin fails++; $display("[TB] FAIL startbusy_hi: got %h expected 00000000", HI); end
        checks++; if (violations != 1) begin fails++; $display("[TB] FAIL startbusy_flagged: got %0d expected 1", violations); end
    endtask

    task automatic test_reset_mid();
        issue(4'd1, 32'd3, 32'd3, 1'b0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL resetmid_busy: got %b expected 0", busy); end
        checks++; if (LO !== 32'h0) begin fails++; $display("[TB] FAIL resetmid_lo: got %h expected 00000000", LO); end
        @(negedge clk); reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (HI !== 32'h0 || LO !== 32'h0) begin fails++; $display("[TB] FAIL resetmid_discard: got %h_%h expected 00000000_00000000", HI, LO); end
    endtask

`ifdef MDU_MADD_EN
    task automatic test_madd();
        int n;
        pulse_reset();
        issue(4'd6, 32'hFFFFFFFF, 32'h0, 1'b0);
        issue(4'd10, 32'd1, 32'd1, 1'b0);
        count_busy(n);
        checks++; if (n != 5) begin fails++; $display("[TB] FAIL maddu_busy_len: got %0d expected 5", n); end
        checks++; if (HI !== 32'd1 || LO !== 32'd0) begin fails++; $display("[TB] FAIL maddu_hilo: got %h_%h expected 00000001_00000000", HI, LO); end
        pulse_reset();
        issue(4'd11, 32'd1, 32'd1, 1'b0);
        count_busy(n);
        checks++; if (n != 5) begin fails++; $display("[TB] FAIL msub_busy_len: got %0d expected 5", n); end
        checks++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFF) begin fails++; $display("[TB] FAIL msub_hilo: got %h_%h expected ffffffff_ffffffff", HI, LO); end
    endtask
`else
    task automatic test_madd_disabled();
        issue(4'd6, 32'h77, 32'h0, 1'b0);
        issue(4'd9, 32'd1, 32'd1, 1'b0);
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL madd_off_busy: got %b expected 0", busy); end
        issue(4'd11, 32'd1, 32'd1, 1'b0);
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL msub_off_busy: got %b expected 0", busy); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (HI !== 32'h0 || LO !== 32'h77) begin fails++; $display("[TB] FAIL madd_off_hilo: got %h_%h expected 00000000_00000077", HI, LO); end
    endtask
`endif

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_req();
        test_req_busy();
        test_mt();
        test_start_busy();
        test_reset_mid();
`ifdef MDU_MADD_EN
        test_madd();
`else
        test_madd_disabled();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
